// File: rtl/kbd_scan_ctrl.sv
// ============================================================================
// Module      : kbd_scan_ctrl
// Description : PS/2 scan-code decoder. Pops bytes from a receiver FIFO,
//               strips E0/F0 prefixes, tracks modifiers and presents key
//               events with ASCII translation under a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_scan_ctrl #(
    parameter int IGNORE_REPEAT = 1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    input  logic       kb_overflow,
    output logic       kb_nextdata_n,
    output logic       key_valid,
    input  logic       key_ack,
    output logic [7:0] key_code,
    output logic [7:0] key_ascii,
    output logic       key_break,
    output logic       key_ext,
    output logic       shift,
    output logic       ctrl,
    output logic       caps,
    output logic       err_overflow
);

    localparam logic [7:0] c_PFX_EXT = 8'hE0;
    localparam logic [7:0] c_PFX_BRK = 8'hF0;
    localparam logic [7:0] c_LSHIFT  = 8'h12;
    localparam logic [7:0] c_RSHIFT  = 8'h59;
    localparam logic [7:0] c_CTRL    = 8'h14;
    localparam logic [7:0] c_CAPS    = 8'h58;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PROC = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_byte;
    logic       r_pend_ext;
    logic       r_pend_brk;
    logic       r_lshift;
    logic       r_rshift;
    logic       r_lctrl;
    logic       r_rctrl;
    logic       r_last_vld;
    logic [8:0] r_last_make;

    logic       w_repeat;
    logic       w_last_hit;
    logic [7:0] w_base;
    logic [7:0] w_alt;
    logic       w_letter;
    logic       w_upper;
    logic [7:0] w_ascii;

    assign shift = r_lshift | r_rshift;
    assign ctrl  = r_lctrl | r_rctrl;

    assign w_last_hit = r_last_vld && (r_last_make == {r_pend_ext, r_byte});
    assign w_repeat   = (IGNORE_REPEAT != 0) && !r_pend_brk && w_last_hit;

    // Unshifted / shifted character pairs; letters carry lower/upper case.
    always_comb begin
        {w_base, w_alt} = 16'h0000;
        case (r_byte)
            8'h1C: {w_base, w_alt} = "aA";
            8'h32: {w_base, w_alt} = "bB";
            8'h21: {w_base, w_alt} = "cC";
            8'h23: {w_base, w_alt} = "dD";
            8'h24: {w_base, w_alt} = "eE";
            8'h2B: {w_base, w_alt} = "fF";
            8'h34: {w_base, w_alt} = "gG";
            8'h33: {w_base, w_alt} = "hH";
            8'h43: {w_base, w_alt} = "iI";
            8'h3B: {w_base, w_alt} = "jJ";
            8'h42: {w_base, w_alt} = "kK";
            8'h4B: {w_base, w_alt} = "lL";
            8'h3A: {w_base, w_alt} = "mM";
            8'h31: {w_base, w_alt} = "nN";
            8'h44: {w_base, w_alt} = "oO";
            8'h4D: {w_base, w_alt} = "pP";
            8'h15: {w_base, w_alt} = "qQ";
            8'h2D: {w_base, w_alt} = "rR";
            8'h1B: {w_base, w_alt} = "sS";
            8'h2C: {w_base, w_alt} = "tT";
            8'h3C: {w_base, w_alt} = "uU";
            8'h2A: {w_base, w_alt} = "vV";
            8'h1D: {w_base, w_alt} = "wW";
            8'h22: {w_base, w_alt} = "xX";
            8'h35: {w_base, w_alt} = "yY";
            8'h1A: {w_base, w_alt} = "zZ";
            8'h16: {w_base, w_alt} = "1!";
            8'h1E: {w_base, w_alt} = "2@";
            8'h26: {w_base, w_alt} = "3#";
            8'h25: {w_base, w_alt} = "4$";
            8'h2E: {w_base, w_alt} = "5%";
            8'h36: {w_base, w_alt} = "6^";
            8'h3D: {w_base, w_alt} = "7&";
            8'h3E: {w_base, w_alt} = "8*";
            8'h46: {w_base, w_alt} = "9(";
            8'h45: {w_base, w_alt} = "0)";
            8'h29: {w_base, w_alt} = 16'h2020;
            8'h5A: {w_base, w_alt} = 16'h0D0D;
            8'h66: {w_base, w_alt} = 16'h0808;
            default: {w_base, w_alt} = 16'h0000;
        endcase
    end

    assign w_letter = (w_base >= 8'h61) && (w_base <= 8'h7A);
    assign w_upper  = w_letter ? (shift ^ caps) : shift;
    assign w_ascii  = (r_pend_brk || r_pend_ext) ? 8'h00 : (w_upper ? w_alt : w_base);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state       <= IDLE;
            r_byte        <= 8'h00;
            r_pend_ext    <= 1'b0;
            r_pend_brk    <= 1'b0;
            r_lshift      <= 1'b0;
            r_rshift      <= 1'b0;
            r_lctrl       <= 1'b0;
            r_rctrl       <= 1'b0;
            r_last_vld    <= 1'b0;
            r_last_make   <= 9'h000;
            kb_nextdata_n <= 1'b1;
            key_valid     <= 1'b0;
            key_code      <= 8'h00;
            key_ascii     <= 8'h00;
            key_break     <= 1'b0;
            key_ext       <= 1'b0;
            caps          <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            if (kb_overflow) begin
                err_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (kb_ready) begin
                        r_byte        <= kb_data;
                        kb_nextdata_n <= 1'b0;
                        r_state       <= POP;
                    end
                end
                POP: begin
                    kb_nextdata_n <= 1'b1;
                    r_state       <= PROC;
                end
                PROC: begin
                    if (r_byte == c_PFX_EXT) begin
                        r_pend_ext <= 1'b1;
                        r_state    <= IDLE;
                    end else if (r_byte == c_PFX_BRK) begin
                        r_pend_brk <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_pend_ext <= 1'b0;
                        r_pend_brk <= 1'b0;
                        if (!r_pend_ext && r_byte == c_LSHIFT) r_lshift <= !r_pend_brk;
                        if (!r_pend_ext && r_byte == c_RSHIFT) r_rshift <= !r_pend_brk;
                        if (r_byte == c_CTRL) begin
                            if (r_pend_ext) r_rctrl <= !r_pend_brk;
                            else            r_lctrl <= !r_pend_brk;
                        end
                        if (!r_pend_brk && !r_pend_ext && r_byte == c_CAPS && !w_repeat) begin
                            caps <= !caps;
                        end
                        // Only a release of the remembered key re-arms the repeat filter.
                        if (!r_pend_brk) begin
                            r_last_vld  <= 1'b1;
                            r_last_make <= {r_pend_ext, r_byte};
                        end else if (w_last_hit) begin
                            r_last_vld <= 1'b0;
                        end
                        if (w_repeat) begin
                            r_state <= IDLE;
                        end else begin
                            key_valid <= 1'b1;
                            key_code  <= r_byte;
                            key_ascii <= w_ascii;
                            key_break <= r_pend_brk;
                            key_ext   <= r_pend_ext;
                            r_state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (key_ack) begin
                        key_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/kbd_scan_ctrl.md
KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

Interface
REQ-001 Parameter: IGNORE_REPEAT, default 1, drops typematic repeat make codes when set to 1.
REQ-002 Port: clk  in  1  system clock; all logic rises on posedge clk.
REQ-003 Port: clrn  in  1  reset, synchronous and active-low.
REQ-004 Port: kb_data  in  8  current FIFO head byte from the PS/2 receiver.
REQ-005 Port: kb_ready  in  1  FIFO non-empty.
REQ-006 Port: kb_overflow  in  1  receiver FIFO overflow flag.
REQ-007 Port: kb_nextdata_n  out  1  pop request to the receiver, active-low, registered.
REQ-008 Port: key_valid  out  1  key event available.
REQ-009 Port: key_ack  in  1  consumer accepts the event.
REQ-010 Port: key_code  out  8  scan code of the event, with E0/F0 prefixes stripped.
REQ-011 Port: key_ascii  out  8  ASCII of the event; 8'h00 if none.
REQ-012 Port: key_break  out  1  event is a release.
REQ-013 Port: key_ext  out  1  event was E0-prefixed.
REQ-014 Port: shift, ctrl, caps  out  1 each  live modifier state.
REQ-015 Port: err_overflow  out  1  sticky overflow indicator.

Function
REQ-016 FSM states SHALL be: IDLE, POP, PROC, HOLD.
REQ-017 IDLE: if kb_ready=1, the block SHALL latch kb_data, drive kb_nextdata_n<=0, and go to POP; otherwise it SHALL stay in IDLE.
REQ-018 POP: the block SHALL drive kb_nextdata_n<=1 and go to PROC; kb_nextdata_n SHALL be low for exactly one cycle per byte.
REQ-019 PROC, byte 8'hE0: the block SHALL set the pending-ext flag and go to IDLE.
REQ-020 PROC, byte 8'hF0: the block SHALL set the pending-break flag and go to IDLE.
REQ-021 PROC, any other byte: the block SHALL form an event {code, ext, break} from the byte and the pending flags, clear both pending flags, update the modifiers, then either go to HOLD with key_valid<=1 or drop the event per REQ-026 and go to IDLE.
REQ-022 HOLD: key_valid and the key_* outputs SHALL stay stable until key_ack=1 is sampled; key_valid<=0 on that edge, then go to IDLE.
REQ-023 key_ack outside HOLD SHALL be ignored.
REQ-024 Latency: kb_ready=1 in IDLE at cycle T SHALL give key_valid=1 from cycle T+3.
REQ-024a A prefix byte SHALL cost 3 cycles.
REQ-024b No byte SHALL be popped while in POP, PROC or HOLD; this is the backpressure rule.
REQ-025 Modifiers:
  - shift = left shift (12) held OR right shift (59) held.
  - ctrl = 14 held, with or without the E0 prefix.
  - caps SHALL toggle on a non-suppressed make of 58.
  - A break SHALL clear the matching held bit.
REQ-026 Repeat filter, IGNORE_REPEAT=1:
  - The block SHALL keep last_make {ext, code}.
  - A make equal to last_make SHALL be dropped, with no event and no caps toggle.
  - A break whose {ext, code} equals last_make SHALL clear last_make.
  - IGNORE_REPEAT=0 SHALL forward every make.
REQ-027 ASCII mapping, for non-ext make events only:
  - Letters: lowercase 61-7A; uppercase 41-5A when shift XOR caps.
  - Digits 30-39; with shift: !@#$%^&*() for 1-9,0.
  - 29 -> 20 (space), 5A -> 0D, 66 -> 08.
  - Break, ext and unmapped events SHALL give 8'h00.
REQ-028 err_overflow SHALL be set whenever kb_overflow=1 is sampled, and cleared only by reset.
REQ-029 The decode sequence E0,F0,xx SHALL give ext=1 and break=1.
REQ-029a A repeated prefix before the code byte SHALL leave its flag set.

Reset
REQ-030 clrn=0 at a posedge SHALL force the following on that edge, from any state including mid-POP or mid-HOLD:
  - state=IDLE
  - kb_nextdata_n=1
  - key_valid=0, key_code=0, key_ascii=0, key_break=0, key_ext=0
  - shift=0, ctrl=0, caps=0, err_overflow=0
  - pending flags and last_make cleared
REQ-031 A byte latched but not yet processed at reset SHALL be discarded without an event.

Verification
REQ-032 kb_data=1C with kb_ready=1 at T -> kb_nextdata_n=0 only in T+1; key_valid=1 at T+3 with code 1C, ascii 61, break=0, ext=0.
REQ-033 Bytes 12, 1C, F0, 12 -> event 12 (ascii 00, shift=1); event 1C (ascii 41); break event 12 (break=1, ascii 00), after which shift=0.
REQ-034 Bytes E0, F0, 75 -> a single event: code 75, ext=1, break=1, ascii 00.
REQ-035 IGNORE_REPEAT=1, bytes 1C, 1C, 1C, F0, 1C -> exactly two events: make 1C, then break 1C.
REQ-035a 58, F0, 58, 1C -> caps=1 and ascii 41.
REQ-036 HOLD with no key_ack for 20 cycles while kb_ready=1 -> kb_nextdata_n stays 1 and the outputs are stable; key_ack=1 -> key_valid=0 on the next edge.
REQ-037 clrn=0 during HOLD with caps=1 and err_overflow=1 -> on the next edge all outputs are at their reset values and the FSM is in IDLE.
